// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- MBIST controller: FSM encoding,
// element indices and the per-element operation tables.
package mbist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int ELEM_W = 3;

   localparam logic [ELEM_W-1:0] E0 = 3'd0;
   localparam logic [ELEM_W-1:0] E1 = 3'd1;
   localparam logic [ELEM_W-1:0] E2 = 3'd2;
   localparam logic [ELEM_W-1:0] E3 = 3'd3;
   localparam logic [ELEM_W-1:0] E4 = 3'd4;
   localparam logic [ELEM_W-1:0] E5 = 3'd5;

   // Bit e of each table describes element e.
   localparam logic [5:0] ELEM_DOWN    = 6'b011000;  // E3, E4 walk N-1..0
   localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;  // E1..E4 are read-then-write
   localparam logic [5:0] SLOT0_WE     = 6'b000001;  // only E0 starts with a write
   localparam logic [5:0] SLOT1_WE     = 6'b011110;  // second slot is always a write
   localparam logic [5:0] SLOT0_BG     = 6'b010100;  // w0 r0 r1 r0 r1 r0
   localparam logic [5:0] SLOT1_BG     = 6'b001010;  // -  w1 w0 w1 w0 -

   function automatic logic elem_down(input logic [ELEM_W-1:0] e);
      return (e <= E5) ? ELEM_DOWN[e] : 1'b0;
   endfunction

   function automatic logic elem_two_ops(input logic [ELEM_W-1:0] e);
      return (e <= E5) ? ELEM_TWO_OPS[e] : 1'b0;
   endfunction

   function automatic logic slot_we(input logic [ELEM_W-1:0] e, input logic s);
      if (e > E5) return 1'b0;
      return s ? SLOT1_WE[e] : SLOT0_WE[e];
   endfunction

   function automatic logic slot_bg(input logic [ELEM_W-1:0] e, input logic s);
      if (e > E5) return 1'b0;
      return s ? SLOT1_BG[e] : SLOT0_BG[e];
   endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Read-data checker: carries expected data alongside each issued op for two
// cycles so it lines up with the SRAM's registered dout, then compares.
// With MBIST_DIAG_EN defined it also latches first-failure diagnostics.
module mbist_cmp
   import mbist_pkg::*;
#(
   parameter int pADDR_WIDTH = 4,
   parameter int pDATA_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   iss_vld,
   input  logic [pDATA_WIDTH-1:0] iss_exp,
   input  logic [pDATA_WIDTH-1:0] mem_dout,
`ifdef MBIST_DIAG_EN
   input  logic [pADDR_WIDTH-1:0] iss_addr,
   input  logic [ELEM_W-1:0]      iss_elem,
   output logic [pADDR_WIDTH-1:0] fail_addr,
   output logic [ELEM_W-1:0]      fail_elem,
   output logic [pDATA_WIDTH-1:0] fail_syn,
`endif
   output logic                   fail_next
);

   logic                   vld_p0_q, vld_p1_q;
   logic [pDATA_WIDTH-1:0] exp_p0_q, exp_p1_q;
   logic                   fail_q, fail_d;
   logic                   mis;

   // Miscompare on a valid read slot; sticky flag cleared by a new run.
   always_comb begin
      mis       = vld_p1_q && (mem_dout != exp_p1_q);
      fail_next = fail_q | mis;
      fail_d    = clr ? 1'b0 : fail_next;
   end

   // Expected-data pipeline and sticky fail flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0_q <= 1'b0;
         vld_p1_q <= 1'b0;
         exp_p0_q <= '0;
         exp_p1_q <= '0;
         fail_q   <= 1'b0;
      end else begin
         vld_p0_q <= iss_vld;
         vld_p1_q <= vld_p0_q;
         exp_p0_q <= iss_exp;
         exp_p1_q <= exp_p0_q;
         fail_q   <= fail_d;
      end
   end

`ifdef MBIST_DIAG_EN
   logic [pADDR_WIDTH-1:0] addr_p0_q, addr_p1_q, faddr_q, faddr_d;
   logic [ELEM_W-1:0]      elem_p0_q, elem_p1_q, felem_q, felem_d;
   logic [pDATA_WIDTH-1:0] fsyn_q, fsyn_d;

   // Capture only the first miscompare of a run; hold until the next start.
   always_comb begin
      faddr_d = faddr_q;
      felem_d = felem_q;
      fsyn_d  = fsyn_q;
      if (clr) begin
         faddr_d = '0;
         felem_d = '0;
         fsyn_d  = '0;
      end else if (mis && !fail_q) begin
         faddr_d = addr_p1_q;
         felem_d = elem_p1_q;
         fsyn_d  = mem_dout ^ exp_p1_q;
      end
   end

   // Address/element pipeline and diagnostic capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_p0_q <= '0;
         addr_p1_q <= '0;
         elem_p0_q <= '0;
         elem_p1_q <= '0;
         faddr_q   <= '0;
         felem_q   <= '0;
         fsyn_q    <= '0;
      end else begin
         addr_p0_q <= iss_addr;
         addr_p1_q <= addr_p0_q;
         elem_p0_q <= iss_elem;
         elem_p1_q <= elem_p0_q;
         faddr_q   <= faddr_d;
         felem_q   <= felem_d;
         fsyn_q    <= fsyn_d;
      end
   end

   assign fail_addr = faddr_q;
   assign fail_elem = felem_q;
   assign fail_syn  = fsyn_q;
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer driving a single-port synchronous SRAM.
// One op per clock for 10N ops, then a two-cycle drain for the last compare.
// Define MBIST_DIAG_EN to enable first-failure address/element/syndrome capture.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int pADDR_WIDTH = 4,
   parameter int pDATA_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   mem_cs,
   output logic                   mem_we,
   output logic [pADDR_WIDTH-1:0] mem_addr,
   output logic [pDATA_WIDTH-1:0] mem_din,
   input  logic [pDATA_WIDTH-1:0] mem_dout,
   output logic [pADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]             fail_elem,
   output logic [pDATA_WIDTH-1:0] fail_syn
);

   localparam logic [pADDR_WIDTH-1:0] ADDR_MAX = {pADDR_WIDTH{1'b1}};

   state_t                 state_q, state_d;
   logic [ELEM_W-1:0]      elem_q, elem_d;
   logic [pADDR_WIDTH-1:0] addr_q, addr_d;
   logic                   slot_q, slot_d;
   logic                   drain_q, drain_d;
   logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic                   mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
   logic [pADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [pDATA_WIDTH-1:0] mem_din_q, mem_din_d;

   logic                   start_ok, issue, last_slot, elem_end, last_op;
   logic [ELEM_W-1:0]      cur_elem, nxt_elem;
   logic [pADDR_WIDTH-1:0] cur_addr;
   logic                   cur_slot, cur_we, cur_bg;
   logic                   iss_vld, fail_next;
   logic [pDATA_WIDTH-1:0] iss_exp;

   // Op issue, counter advance and FSM next-state.
   always_comb begin
      state_d    = state_q;
      elem_d     = elem_q;
      addr_d     = addr_q;
      slot_d     = slot_q;
      drain_d    = drain_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      mem_cs_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = '0;
      mem_din_d  = '0;
      iss_vld    = 1'b0;
      iss_exp    = '0;

      // The start edge itself issues op 0, so the counters are bypassed then.
      start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
      issue     = start_ok || (state_q == RUN);
      cur_elem  = start_ok ? E0 : elem_q;
      cur_addr  = start_ok ? '0 : addr_q;
      cur_slot  = start_ok ? 1'b0 : slot_q;
      cur_we    = slot_we(cur_elem, cur_slot);
      cur_bg    = slot_bg(cur_elem, cur_slot);
      nxt_elem  = cur_elem + 3'd1;
      last_slot = !elem_two_ops(cur_elem) || cur_slot;
      elem_end  = elem_down(cur_elem) ? (cur_addr == '0) : (cur_addr == ADDR_MAX);
      last_op   = issue && last_slot && elem_end && (cur_elem == E5);

      if (issue) begin
         mem_cs_d   = 1'b1;
         mem_we_d   = cur_we;
         mem_addr_d = cur_addr;
         mem_din_d  = cur_we ? {pDATA_WIDTH{cur_bg}} : '0;
         iss_vld    = !cur_we;
         iss_exp    = {pDATA_WIDTH{cur_bg}};
         if (!last_slot) begin
            slot_d = 1'b1;
         end else begin
            slot_d = 1'b0;
            if (last_op) begin
               elem_d = E0;
               addr_d = '0;
            end else if (elem_end) begin
               elem_d = nxt_elem;
               addr_d = elem_down(nxt_elem) ? ADDR_MAX : '0;
            end else begin
               addr_d = elem_down(cur_elem) ? (cur_addr - 1'b1) : (cur_addr + 1'b1);
            end
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               state_d = RUN;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            if (last_op) begin
               state_d = DRAIN;
               drain_d = 1'b0;
            end
         end
         DRAIN: begin
            // Second drain cycle is when the final read's dout is compared.
            if (drain_q) begin
               state_d = DONE;
               drain_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = !fail_next;
            end else begin
               drain_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered SRAM pins; reset drops mem_cs at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         elem_q     <= E0;
         addr_q     <= '0;
         slot_q     <= 1'b0;
         drain_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         mem_cs_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         elem_q     <= elem_d;
         addr_q     <= addr_d;
         slot_q     <= slot_d;
         drain_q    <= drain_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         mem_cs_q   <= mem_cs_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
      end
   end

   mbist_cmp #(
      .pADDR_WIDTH(pADDR_WIDTH),
      .pDATA_WIDTH(pDATA_WIDTH)
   ) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (start_ok),
      .iss_vld   (iss_vld),
      .iss_exp   (iss_exp),
      .mem_dout  (mem_dout),
`ifdef MBIST_DIAG_EN
      .iss_addr  (cur_addr),
      .iss_elem  (cur_elem),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .fail_syn  (fail_syn),
`endif
      .fail_next (fail_next)
   );

`ifndef MBIST_DIAG_EN
   assign fail_addr = '0;
   assign fail_elem = '0;
   assign fail_syn  = '0;
`endif

   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign mem_cs   = mem_cs_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural SRAM with injectable faults,
// table of full runs plus reset/abort sequences.
module tb_mbist_march_ctrl;

   localparam int AW  = 4;
   localparam int DW  = 2;
   localparam int N   = 16;
   localparam int OPS = 10 * N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          busy, done, pass;
   logic          mem_cs, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout = '0;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;
   logic [DW-1:0] fail_syn;

   int checks   = 0;
   int failures = 0;
   int fault_mode = 0;

   logic [DW-1:0] mem [N];

   mbist_march_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_syn(fail_syn)
   );

   always #5 clk = ~clk;

   // Read path applies the selected fault: 1 = word 5 bit 1 stuck-at-1, 2 = word 9 bit 0 stuck-at-0.
   function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
      if (fault_mode == 1 && a == 4'd5) r[1] = 1'b1;
      if (fault_mode == 2 && a == 4'd9) r[0] = 1'b0;
      return r;
   endfunction

   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we) mem[mem_addr] <= mem_din;
         else        mem_dout      <= faulty(mem_addr, mem[mem_addr]);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int fault;
      bit mid_start;
      bit spot;
      int exp_pass;
      int exp_elem;
      int exp_addr;
      int exp_syn;
   } vec_t;

   vec_t vecs[5];

   function automatic int pins();
      return int'({mem_cs, mem_we, mem_addr, mem_din});
   endfunction

   // Launch one run and check timing, op stream spot values and result.
   task automatic run_and_check(input string tag, input vec_t v);
      int busy_cnt, cs_cnt, done_at;
      busy_cnt = 0;
      cs_cnt   = 0;
      done_at  = -1;
      fault_mode = v.fault;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int j = 0; j < 400 && done_at < 0; j++) begin
         if (j > 0) @(negedge clk);
         if (j == 0) begin
            check({tag, " done_cleared"}, int'(done), 0);
            check({tag, " diag_cleared"}, int'({fail_addr, fail_elem, fail_syn}), 0);
            check({tag, " busy_at_S"}, int'(busy), 1);
         end
         if (v.mid_start) start = (j == 49);
         busy_cnt += int'(busy);
         cs_cnt   += int'(mem_cs);
         if (v.spot) begin
            case (j)
               0:   check({tag, " op0_w0_a0"},    pins(), 'hC0);
               16:  check({tag, " op16_r0_a0"},   pins(), 'h80);
               17:  check({tag, " op17_w1_a0"},   pins(), 'hC3);
               47:  check({tag, " op47_w1_a15"},  pins(), 'hFF);
               48:  check({tag, " op48_r1_a0"},   pins(), 'h80);
               80:  check({tag, " op80_r0_a15"},  pins(), 'hBC);
               81:  check({tag, " op81_w1_a15"},  pins(), 'hFF);
               111: check({tag, " op111_w1_a0"},  pins(), 'hC3);
               112: check({tag, " op112_r1_a15"}, pins(), 'hBC);
               144: check({tag, " op144_r0_a0"},  pins(), 'h80);
               159: check({tag, " op159_r0_a15"}, pins(), 'hBC);
               160: check({tag, " idle_pins"},    pins(), 0);
               default: ;
            endcase
         end
         if (done && done_at < 0) done_at = j;
      end
      start = 1'b0;
      check({tag, " done_cycle"}, done_at, OPS + 1);
      check({tag, " busy_cycles"}, busy_cnt, OPS + 1);
      check({tag, " cs_cycles"}, cs_cnt, OPS);
      check({tag, " busy_low_at_done"}, int'(busy), 0);
      check({tag, " pass"}, int'(pass), v.exp_pass);
`ifdef MBIST_DIAG_EN
      check({tag, " fail_elem"}, int'(fail_elem), v.exp_elem);
      check({tag, " fail_addr"}, int'(fail_addr), v.exp_addr);
      check({tag, " fail_syn"},  int'(fail_syn),  v.exp_syn);
`else
      check({tag, " fail_elem_tied"}, int'(fail_elem), 0);
      check({tag, " fail_addr_tied"}, int'(fail_addr), 0);
      check({tag, " fail_syn_tied"},  int'(fail_syn),  0);
`endif
   endtask

   initial begin
      //          fault mid spot pass elem addr syn
      vecs[0] = '{0, 1'b0, 1'b1, 1, 0, 0, 0};
      vecs[1] = '{1, 1'b0, 1'b0, 0, 1, 5, 2};
      vecs[2] = '{2, 1'b0, 1'b1, 0, 2, 9, 1};
      vecs[3] = '{0, 1'b1, 1'b0, 1, 0, 0, 0};
      vecs[4] = '{1, 1'b1, 1'b0, 0, 1, 5, 2};

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst busy",   int'(busy),   0);
      check("rst done",   int'(done),   0);
      check("rst pass",   int'(pass),   0);
      check("rst mem_cs", int'(mem_cs), 0);
      check("rst pins",   pins(),       0);
      check("rst diag",   int'({fail_addr, fail_elem, fail_syn}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle busy", int'(busy), 0);

      for (int i = 0; i < 5; i++) begin
         run_and_check($sformatf("vec%0d", i), vecs[i]);
         repeat (3) @(negedge clk);
         check($sformatf("vec%0d done_hold", i), int'(done), 1);
      end

      // Abort mid-run with an asynchronous reset, then a clean run from IDLE.
      fault_mode = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (80) @(negedge clk);
      check("abort cs_before", int'(mem_cs), 1);
      check("abort busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("abort mem_cs", int'(mem_cs), 0);
      check("abort busy",   int'(busy),   0);
      check("abort done",   int'(done),   0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      run_and_check("after_abort", vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
